// File: rtl/service_4_led_pattern_gen.sv
// Target-pattern source for the alarm-off minigame: draws sparse pseudo-random LED
// patterns from a Galois LFSR, holds them while matched and redraws them on timeout.
module service_4_led_pattern_gen #(
    parameter int          WIDTH     = 10,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_ONES  = 4,
    parameter int          TIMEOUT   = 100_000_000,
    parameter int          MAX_TRIES = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       alarm_state,
    input  logic [WIDTH-1:0] SPDTs,
    output logic [WIDTH-1:0] random_led,
    output logic             pattern_valid,
    output logic             matched,
    output logic             redraw_pulse
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_DRAW = 2'b01;
    localparam logic [1:0] S_SHOW = 2'b10;
    localparam logic [1:0] S_LOCK = 2'b11;
    localparam logic [2:0] GAME_STATE = 3'b100;
    localparam int CW = $clog2(WIDTH + 1);

    logic [15:0]      lfsr_reg, lfsr_next;
    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] led_reg, led_next;
    logic [WIDTH-1:0] last_reg, last_next;
    logic [3:0]       tries_reg, tries_next;
    logic [31:0]      timer_reg, timer_next;
    logic             pulse_reg, pulse_next;

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] fallback;
    logic [WIDTH-1:0] pick;
    logic [CW-1:0]    ones;
    logic             cand_ok;
    logic             active;

    assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
    assign cand      = lfsr_reg[WIDTH-1:0];
    assign active    = (alarm_state == GAME_STATE);

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(cand[i]);
        end
    end

    // Rotating the last pattern keeps its sparsity and guarantees a different target.
    assign fallback = (last_reg != '0) ? {last_reg[WIDTH-2:0], last_reg[WIDTH-1]}
                                       : {{(WIDTH-1){1'b0}}, 1'b1};
    assign cand_ok  = (cand != '0) && (ones <= CW'(MAX_ONES)) && (cand != last_reg);
    assign pick     = cand_ok ? cand : fallback;

    always_comb begin
        state_next = state_reg;
        led_next   = led_reg;
        last_next  = last_reg;
        tries_next = tries_reg;
        timer_next = timer_reg;
        pulse_next = 1'b0;
        if (state_reg != S_IDLE && !active) begin
            state_next = S_IDLE;
            led_next   = '0;
            tries_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (active) state_next = S_DRAW;
                end
                S_DRAW: begin
                    if (cand_ok || tries_reg == 4'(MAX_TRIES)) begin
                        led_next   = pick;
                        last_next  = pick;
                        timer_next = '0;
                        tries_next = '0;
                        state_next = S_SHOW;
                    end else begin
                        tries_next = tries_reg + 4'd1;
                    end
                end
                S_SHOW: begin
                    if (SPDTs == led_reg) begin
                        state_next = S_LOCK;
                    end else if (timer_reg == 32'(TIMEOUT - 1)) begin
                        state_next = S_DRAW;
                        pulse_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + 32'd1;
                    end
                end
                default: begin
                    if (SPDTs != led_reg) begin
                        state_next = S_SHOW;
                        timer_next = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_reg  <= SEED;
            state_reg <= S_IDLE;
            led_reg   <= '0;
            last_reg  <= '0;
            tries_reg <= '0;
            timer_reg <= '0;
            pulse_reg <= 1'b0;
        end else begin
            lfsr_reg  <= lfsr_next;
            state_reg <= state_next;
            led_reg   <= led_next;
            last_reg  <= last_next;
            tries_reg <= tries_next;
            timer_reg <= timer_next;
            pulse_reg <= pulse_next;
        end
    end

    assign random_led    = led_reg;
    assign pattern_valid = (state_reg == S_SHOW) || (state_reg == S_LOCK);
    assign matched       = (state_reg == S_LOCK);
    assign redraw_pulse  = pulse_reg;

endmodule

// File: tb/tb_service_4_led_pattern_gen.sv
// Bench for service_4_led_pattern_gen: two instances (MAX_ONES=4 and MAX_ONES=1) checked
// every cycle against a draw-planning reference model, plus directed corner sequences.
module tb_service_4_led_pattern_gen;

    localparam int W  = 10;
    localparam int TO = 20;
    localparam int MT = 15;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int M_IDLE = 0;
    localparam int M_DRAW = 1;
    localparam int M_SHOW = 2;
    localparam int M_LOCK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic [2:0]   alarm_state;
    logic [W-1:0] spdts0, spdts1, led0, led1;
    logic         valid0, valid1, match0, match1, pulse0, pulse1;

    service_4_led_pattern_gen #(.WIDTH(W), .SEED(SEED), .MAX_ONES(4), .TIMEOUT(TO), .MAX_TRIES(MT)) dut0 (
        .clk(clk), .resetn(resetn), .alarm_state(alarm_state), .SPDTs(spdts0),
        .random_led(led0), .pattern_valid(valid0), .matched(match0), .redraw_pulse(pulse0));

    service_4_led_pattern_gen #(.WIDTH(W), .SEED(SEED), .MAX_ONES(1), .TIMEOUT(TO), .MAX_TRIES(MT)) dut1 (
        .clk(clk), .resetn(resetn), .alarm_state(alarm_state), .SPDTs(spdts1),
        .random_led(led1), .pattern_valid(valid1), .matched(match1), .redraw_pulse(pulse1));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each draw is planned in full when DRAW is entered.
    int           max_ones_of [2] = '{4, 1};
    int           m_mode  [2];
    logic [15:0]  m_lfsr  [2];
    logic [W-1:0] m_led   [2];
    logic [W-1:0] m_last  [2];
    logic [W-1:0] m_pat   [2];
    int           m_left  [2];
    int           m_shown [2];
    logic         m_pulse [2];

    typedef struct {
        logic [2:0]   as;
        logic [W-1:0] sp;
        logic [W-1:0] exp_led;
        logic         exp_valid;
        logic         exp_match;
        logic         exp_pulse;
    } vec_t;
    vec_t vecs [7];

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        if (x % 2 == 1) return (x / 2) ^ 16'hB400;
        return x / 2;
    endfunction

    function automatic int popcnt(input logic [W-1:0] v);
        int c = 0;
        for (int i = 0; i < W; i++) if (v[i]) c++;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic plan_draw(input int k, input logic [15:0] start);
        logic [15:0]  x;
        logic [W-1:0] c;
        logic [W-1:0] l;
        bit           found;
        x = start;
        found = 0;
        for (int j = 0; j <= MT; j++) begin
            c = x[W-1:0];
            if (!found && c != 0 && popcnt(c) <= max_ones_of[k] && c != m_last[k]) begin
                found = 1;
                m_pat[k] = c;
                m_left[k] = j + 1;
            end
            x = lfsr_step(x);
        end
        if (!found) begin
            l = m_last[k];
            m_left[k] = MT + 1;
            if (l != 0) m_pat[k] = (l << 1) | (l >> (W - 1));
            else m_pat[k] = W'(1);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_lfsr[k] = SEED; m_led[k] = '0; m_last[k] = '0;
            m_pat[k] = '0; m_left[k] = 0; m_shown[k] = 0; m_pulse[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [2:0] as, input logic [W-1:0] sp);
        logic [15:0] nl;
        nl = lfsr_step(m_lfsr[k]);
        m_pulse[k] = 1'b0;
        if (m_mode[k] != M_IDLE && as != 3'b100) begin
            m_mode[k] = M_IDLE;
            m_led[k] = '0;
        end else begin
            case (m_mode[k])
                M_IDLE: if (as == 3'b100) begin m_mode[k] = M_DRAW; plan_draw(k, nl); end
                M_DRAW: begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_led[k] = m_pat[k]; m_last[k] = m_pat[k];
                        m_mode[k] = M_SHOW; m_shown[k] = 0;
                    end
                end
                M_SHOW: begin
                    if (sp == m_led[k]) m_mode[k] = M_LOCK;
                    else begin
                        m_shown[k]++;
                        if (m_shown[k] == TO) begin
                            m_mode[k] = M_DRAW; m_pulse[k] = 1'b1; plan_draw(k, nl);
                        end
                    end
                end
                default: if (sp != m_led[k]) begin m_mode[k] = M_SHOW; m_shown[k] = 0; end
            endcase
        end
        m_lfsr[k] = nl;
    endtask

    task automatic compare_all();
        check("dut0_led",     led0,   m_led[0]);
        check("dut0_valid",   valid0, (m_mode[0] == M_SHOW || m_mode[0] == M_LOCK));
        check("dut0_matched", match0, (m_mode[0] == M_LOCK));
        check("dut0_pulse",   pulse0, m_pulse[0]);
        check("dut1_led",     led1,   m_led[1]);
        check("dut1_valid",   valid1, (m_mode[1] == M_SHOW || m_mode[1] == M_LOCK));
        check("dut1_matched", match1, (m_mode[1] == M_LOCK));
        check("dut1_pulse",   pulse1, m_pulse[1]);
    endtask

    task automatic cycle(input logic [2:0] as, input logic [W-1:0] s0, input logic [W-1:0] s1);
        alarm_state = as; spdts0 = s0; spdts1 = s1;
        @(posedge clk);
        model_step(0, as, s0);
        model_step(1, as, s1);
        #1;
        compare_all();
    endtask

    // Runs until dut0 shows a pattern; returns edges taken (bounded, 99 on expiry).
    task automatic wait_valid(input string name, output int lat);
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            cycle(3'b100, '0, '0);
            if (valid0) begin lat = c; break; end
        end
        check(name, valid0, 1);
    endtask

    initial begin
        logic [W-1:0] first_pat, pat, pat2, lb, s0, s1;
        logic [2:0]   as;
        int           lat, c, run1;
        bit           pv;

        vecs[0] = '{3'b000, 10'h000, '0, 0, 0, 0};
        vecs[1] = '{3'b001, 10'h3FF, '0, 0, 0, 0};
        vecs[2] = '{3'b010, 10'h001, '0, 0, 0, 0};
        vecs[3] = '{3'b011, 10'h000, '0, 0, 0, 0};
        vecs[4] = '{3'b101, 10'h155, '0, 0, 0, 0};
        vecs[5] = '{3'b110, 10'h000, '0, 0, 0, 0};
        vecs[6] = '{3'b111, 10'h2AA, '0, 0, 0, 0};

        resetn = 1'b0; alarm_state = 3'b000; spdts0 = '0; spdts1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].as, vecs[i].sp, vecs[i].sp);
            check("idle_led",   led0,   vecs[i].exp_led);
            check("idle_valid", valid0, vecs[i].exp_valid);
            check("idle_match", match0, vecs[i].exp_match);
            check("idle_pulse", pulse0, vecs[i].exp_pulse);
        end

        wait_valid("first_valid", lat);
        check("first_latency_in_2_17", (lat >= 2 && lat <= 17), 1);
        check("first_nonzero", (led0 != 0), 1);
        check("first_popcnt_le4", (popcnt(led0) <= 4), 1);
        first_pat = m_led[0];

        pat = m_led[0];
        for (int i = 0; i < 4; i++) begin
            cycle(3'b100, pat, '0);
            check("hold_matched", match0, 1);
            check("hold_pattern", led0, pat);
        end
        cycle(3'b100, '0, '0);
        check("unmatch_matched", match0, 0);
        check("unmatch_valid", valid0, 1);
        check("unmatch_pattern", led0, pat);

        c = 99;
        for (int i = 1; i <= 25; i++) begin
            cycle(3'b100, '0, '0);
            if (pulse0) begin c = i; break; end
        end
        check("timeout_cycles", c, TO);
        check("timeout_valid_drop", valid0, 0);
        cycle(3'b100, '0, '0);
        check("pulse_one_cycle", pulse0, 0);
        if (!valid0) wait_valid("redraw_valid", lat);
        check("redraw_differs", (led0 != pat), 1);

        pat2 = m_led[0];
        repeat (19) cycle(3'b100, '0, '0);
        cycle(3'b100, pat2, '0);
        check("late_match_lock", match0, 1);
        check("late_match_no_pulse", pulse0, 0);
        check("late_match_pattern", led0, pat2);

        cycle(3'b001, pat2, '0);
        check("abort_lock_led", led0, 0);
        check("abort_lock_valid", valid0, 0);
        wait_valid("reenter_lock_valid", lat);
        check("reenter_lock_differs", (led0 != pat2), 1);

        pat = m_led[0];
        cycle(3'b001, '0, '0);
        check("abort_show_led", led0, 0);
        cycle(3'b100, '0, '0);
        check("draw_not_valid", valid0, 0);
        cycle(3'b001, '0, '0);
        check("abort_draw_led", led0, 0);
        check("abort_draw_valid", valid0, 0);
        wait_valid("reenter_draw_valid", lat);
        check("reenter_draw_differs", (led0 != pat), 1);

        pat = m_led[0];
        cycle(3'b100, pat, '0);
        check("pre_reset_lock", match0, 1);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_led", led0, 0);
        check("async_rst_valid", valid0, 0);
        check("async_rst_matched", match0, 0);
        check("async_rst_led1", led1, 0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) cycle(vecs[i].as, '0, '0);
        wait_valid("restart_valid", lat);
        check("restart_from_seed", led0, first_pat);

        run1 = 0;
        for (int i = 0; i < 1500; i++) begin
            as = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
            s0 = ($urandom_range(0, 2) == 0) ? m_led[0] : W'($urandom);
            s1 = ($urandom_range(0, 3) == 0) ? m_led[1] : W'($urandom);
            lb = m_last[1];
            pv = valid1;
            cycle(as, s0, s1);
            if (as != 3'b100) run1 = 0;
            else if (!valid1) run1++;
            if (valid1 && !pv) begin
                check("fallback_onehot", popcnt(led1), 1);
                check("fallback_differs", (led1 != lb), 1);
                check("fallback_draw_len", (run1 >= 1 && run1 <= MT + 1), 1);
                run1 = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/service_4_led_pattern_gen.md
# service_4_led_pattern_gen

Pattern source for the alarm-off minigame. It drives the 10-bit `random_led` target that the minigame compares against `SPDTs`. A new pseudo-random pattern is drawn each time the alarm FSM enters its minigame state (`3'b100`). Once the player matches the pattern, it is held stable so the minigame can count consecutive matches. If the player fails to match before a timeout, the pattern is redrawn.

## Interface

Parameters:
- `WIDTH`, default 10: LED/switch width.
- `SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.
- `MAX_ONES`, default 4: maximum number of set bits in a pattern. Legal range 1..WIDTH.
- `TIMEOUT`, default 100_000_000: cycles a pattern may be shown without a match before redraw. Must be ≥2.
- `MAX_TRIES`, default 15: rejected LFSR candidates allowed before the fallback pattern is used.

Ports:
- `clk`, in, 1: system clock.
- `resetn`, in, 1: reset, **asynchronous, active-low**.
- `alarm_state`, in, 3: alarm FSM state. `3'b100` means minigame active.
- `SPDTs`, in, WIDTH: player switch inputs, already synchronised upstream.
- `random_led`, out, WIDTH: current target pattern.
- `pattern_valid`, out, 1: high while `random_led` holds a drawn, playable pattern.
- `matched`, out, 1: high while in LOCK, meaning `SPDTs == random_led` on a valid pattern.
- `redraw_pulse`, out, 1: one-cycle pulse when a pattern is abandoned on timeout.

## Operation

- **LFSR**
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every cycle in every state.
  - The candidate pattern is `lfsr[WIDTH-1:0]`.
- **Registers**
  - `last`: the previously accepted pattern. Preserved across IDLE.
  - `tries`: 4-bit retry counter.
  - `timer`: 32-bit timeout counter.
- **FSM states**
  - **IDLE**
    - Outputs: `random_led`=0, `pattern_valid`=0, `matched`=0.
    - `alarm_state==3'b100` → DRAW.
  - **DRAW**
    - Accept the candidate if all three hold: it is nonzero, its popcount ≤ MAX_ONES, and it differs from `last`.
    - On accept: load `random_led` and `last` with the candidate, clear `timer`, go to SHOW.
    - On reject: increment `tries`.
    - When `tries==MAX_TRIES`, load the fallback instead of the candidate:
      - `last` rotated left by one if `last` is nonzero;
      - otherwise `{{WIDTH-1{1'b0}},1'b1}`.
    - `tries` clears on leaving DRAW.
    - `random_led` keeps its previous value in DRAW. `pattern_valid`=0.
  - **SHOW**
    - `pattern_valid`=1. `timer` increments.
    - `SPDTs==random_led` → LOCK. `timer` is frozen.
    - Otherwise, if `timer==TIMEOUT-1` → DRAW, with `redraw_pulse`=1 for that cycle.
    - Match takes priority over timeout in the same cycle.
  - **LOCK**
    - `pattern_valid`=1, `matched`=1. Pattern held.
    - `SPDTs!=random_led` → SHOW with `timer` cleared.
- **Abort**
  - In any non-IDLE state, `alarm_state!=3'b100` → IDLE next edge.
  - `random_led` clears to 0. `last` and `lfsr` are retained.
  - Abort has priority over all other transitions.
- **Reset**
  - Asynchronous to IDLE.
  - `lfsr`=SEED, `last`=0, `tries`=0, `timer`=0.
  - All outputs 0.
  - Reset mid-DRAW/SHOW/LOCK discards the pattern.

## Timing

- All outputs are registered. No combinational input→output paths.
- `alarm_state` becomes `3'b100` before edge n → DRAW after edge n.
- Earliest valid pattern is after edge n+1. Worst case is after edge n+1+MAX_TRIES.
- A match sampled at edge k → `matched`=1 after edge k.
- The pattern never changes while in LOCK. This lets the downstream 3-consecutive-match counter complete.
- Timeout: a pattern with no match is valid for exactly TIMEOUT cycles. `pattern_valid` then drops for ≥1 DRAW cycle.
- Back-to-back rounds: leaving and re-entering `3'b100` always yields a pattern ≠ `last`.

## Test plan

- **Reset and first draw.** Release reset, hold `alarm_state`=3'b000 for 5 cycles: all outputs 0. Set 3'b100: `pattern_valid` rises within 2..17 cycles. The pattern is nonzero, popcount ≤4, and matches the reference-model LFSR from 16'hACE1.
- **Match and hold.** Drive `SPDTs`=`random_led` for 4 cycles: `matched`=1 from the next edge and the pattern is unchanged. Then drive `SPDTs`=0: back to SHOW with `matched`=0, same pattern.
- **Timeout.** Set TIMEOUT=20 and hold `SPDTs`=0: after exactly 20 SHOW cycles `redraw_pulse`=1 for one cycle, then a new pattern ≠ old. A match on cycle 20 instead → LOCK with no pulse.
- **Fallback.** Set MAX_ONES=1 and WIDTH=10: every draw completes within MAX_TRIES+1 cycles. Every pattern is one-hot and differs from the previous one.
- **Abort.** Drive `alarm_state` to 3'b001 during SHOW, LOCK and DRAW: IDLE next edge, `random_led`=0. Re-enter 3'b100: the new pattern ≠ the pattern before abort.
- **Async reset.** Assert `resetn`=0 mid-cycle in LOCK: outputs go to 0 immediately, without waiting for a clock edge. After release, the LFSR restarts at SEED.
